// File: rtl/imem_debug_port.sv
// Instruction memory with a debug load/read-back port arbitrated against the core fetch port.
// Debug requests are edge-triggered and serviced by a small FSM; fetch is registered.
module imem_debug_port #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned CW    = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            dbg_wr_en_i,
  input  logic [XLEN-1:0] dbg_addr_i,
  input  logic [XLEN-1:0] dbg_instr_i,
  input  logic            dbg_rd_en_i,
  output logic [XLEN-1:0] dbg_rd_data_o,
  output logic            dbg_rd_valid_o,
  output logic            dbg_err_o,
  output logic            dbg_busy_o,
  output logic [CW-1:0]   dbg_wr_count_o,
  input  logic [XLEN-1:0] fetch_addr_i,
  output logic [XLEN-1:0] fetch_instr_o,
  output logic            fetch_stall_o
);

  localparam int unsigned     AW    = $clog2(DEPTH);
  localparam logic [XLEN-1:0] Limit = XLEN'(DEPTH * 4);
  localparam logic [XLEN-1:0] Nop   = XLEN'(32'h0000_0013);

  typedef enum logic [1:0] {StIdle, StWrite, StRead} state_e;

  state_e          state_q, state_d;
  logic            wr_q, rd_q;
  logic [AW-1:0]   idx_q, idx_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            coll_q, coll_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d;
  logic            rd_valid_q, rd_valid_d;
  logic            err_q, err_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] fetch_instr_q, fetch_instr_d;
  logic            fetch_stall_q, fetch_stall_d;

  logic [XLEN-1:0] mem [DEPTH];

  logic          wr_rise, rd_rise, dbg_legal, fetch_legal;
  logic [AW-1:0] dbg_idx, fetch_idx;

  assign wr_rise     = dbg_wr_en_i & ~wr_q;
  assign rd_rise     = dbg_rd_en_i & ~rd_q;
  assign dbg_legal   = (dbg_addr_i[1:0] == 2'b00) && (dbg_addr_i < Limit);
  assign fetch_legal = (fetch_addr_i[1:0] == 2'b00) && (fetch_addr_i < Limit);
  assign dbg_idx     = dbg_addr_i[AW+1:2];
  assign fetch_idx   = fetch_addr_i[AW+1:2];

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    wdata_d       = wdata_q;
    coll_d        = coll_q;
    rd_data_d     = rd_data_q;
    rd_valid_d    = 1'b0;
    err_d         = err_q;
    count_d       = count_q;
    fetch_instr_d = fetch_instr_q;
    fetch_stall_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (wr_rise) begin
          if (dbg_legal) begin
            state_d = StWrite;
            idx_d   = dbg_idx;
            wdata_d = dbg_instr_i;
            // A simultaneous read is dropped but must still be flagged once the write completes.
            coll_d  = rd_rise;
          end else begin
            err_d = 1'b1;
          end
        end else if (rd_rise) begin
          if (dbg_legal) begin
            state_d = StRead;
            idx_d   = dbg_idx;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StWrite: begin
        if (count_q != {CW{1'b1}}) count_d = count_q + CW'(1);
        err_d   = coll_q;
        state_d = StIdle;
      end
      StRead: begin
        rd_data_d  = mem[idx_q];
        rd_valid_d = 1'b1;
        err_d      = 1'b0;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (state_q != StIdle) begin
      fetch_stall_d = 1'b1;
    end else begin
      fetch_instr_d = fetch_legal ? mem[fetch_idx] : Nop;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      wr_q          <= 1'b0;
      rd_q          <= 1'b0;
      idx_q         <= '0;
      wdata_q       <= '0;
      coll_q        <= 1'b0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      err_q         <= 1'b0;
      count_q       <= '0;
      fetch_instr_q <= '0;
      fetch_stall_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_q          <= dbg_wr_en_i;
      rd_q          <= dbg_rd_en_i;
      idx_q         <= idx_d;
      wdata_q       <= wdata_d;
      coll_q        <= coll_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
      err_q         <= err_d;
      count_q       <= count_d;
      fetch_instr_q <= fetch_instr_d;
      fetch_stall_q <= fetch_stall_d;
    end
  end

  // Memory is deliberately left out of reset; an async reset drops state_q out of StWrite.
  always_ff @(posedge clk_i) begin
    if (state_q == StWrite) mem[idx_q] <= wdata_q;
  end

  assign dbg_rd_data_o  = rd_data_q;
  assign dbg_rd_valid_o = rd_valid_q;
  assign dbg_err_o      = err_q;
  assign dbg_busy_o     = (state_q != StIdle);
  assign dbg_wr_count_o = count_q;
  assign fetch_instr_o  = fetch_instr_q;
  assign fetch_stall_o  = fetch_stall_q;

endmodule

// File: tb/tb_imem_debug_port.sv
// Bench for imem_debug_port: vector table, hand-written corner sequences and random ops
// against an array-based reference model; a CW=2 instance shares stimulus for saturation.
module tb_imem_debug_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [31:0] addr = '0, instr = '0, fetch_addr = '0;

  logic [31:0] rd_data, fetch_instr, s_rd_data, s_fetch_instr;
  logic        rd_valid, err, busy, fetch_stall, s_rd_valid, s_err, s_busy, s_fetch_stall;
  logic [15:0] count;
  logic [1:0]  s_count;

  imem_debug_port dut (
    .clk_i(clk), .rst_i(rst), .dbg_wr_en_i(wr_en), .dbg_addr_i(addr), .dbg_instr_i(instr),
    .dbg_rd_en_i(rd_en), .dbg_rd_data_o(rd_data), .dbg_rd_valid_o(rd_valid), .dbg_err_o(err),
    .dbg_busy_o(busy), .dbg_wr_count_o(count), .fetch_addr_i(fetch_addr),
    .fetch_instr_o(fetch_instr), .fetch_stall_o(fetch_stall)
  );

  imem_debug_port #(.CW(2)) dut_sat (
    .clk_i(clk), .rst_i(rst), .dbg_wr_en_i(wr_en), .dbg_addr_i(addr), .dbg_instr_i(instr),
    .dbg_rd_en_i(rd_en), .dbg_rd_data_o(s_rd_data), .dbg_rd_valid_o(s_rd_valid),
    .dbg_err_o(s_err), .dbg_busy_o(s_busy), .dbg_wr_count_o(s_count),
    .fetch_addr_i(fetch_addr), .fetch_instr_o(s_fetch_instr), .fetch_stall_o(s_fetch_stall)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int rv_cnt = 0;
  logic [31:0] rv_data = '0;

  always @(negedge clk) if (rd_valid) begin
    rv_cnt  <= rv_cnt + 1;
    rv_data <= rd_data;
  end

  // Reference model: word array, written flags, commit counters.
  logic [31:0] mem_m [256];
  bit          wr_m [256];
  int unsigned cnt_m = 0, sat_m = 0;

  typedef struct {
    bit          wr, rd;
    logic [31:0] addr, data;
    int          hold;
    bit          err;
    int          rv;
    logic [31:0] rdata;
    int          cnt, sat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic bit legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a < 32'd1024);
  endfunction

  task automatic model_op(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d,
                          output bit e, output int rv, output bit known, output logic [31:0] rdat);
    rv = 0; known = 0; rdat = '0; e = 0;
    if (w) begin
      if (legal(a)) begin
        mem_m[a >> 2] = d;
        wr_m[a >> 2]  = 1;
        if (cnt_m < 65535) cnt_m++;
        if (sat_m < 3) sat_m++;
        e = r;
      end else e = 1;
    end else if (r) begin
      if (legal(a)) begin
        rv = 1; known = wr_m[a >> 2]; rdat = mem_m[a >> 2];
      end else e = 1;
    end
  endtask

  task automatic do_op(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d,
                       input int hold, output int rv_seen, output logic [31:0] rv_d);
    int rv0;
    rv0 = rv_cnt;
    wr_en = w; rd_en = r; addr = a; instr = d;
    cyc(hold);
    wr_en = 0; rd_en = 0;
    cyc(4);
    rv_seen = rv_cnt - rv0;
    rv_d    = rv_data;
  endtask

  vec_t        vecs [11];
  int          rv_seen;
  logic [31:0] rv_d, exp_f;
  bit          e_m, known;
  int          rv_m;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1, 0, 32'd4,    32'hE750_8113, 1, 0, 0, 32'h0,         1, 1};
    vecs[1]  = '{0, 1, 32'd4,    32'h0,         1, 0, 1, 32'hE750_8113, 1, 1};
    vecs[2]  = '{1, 0, 32'd8,    32'h5591_0193, 5, 0, 0, 32'h0,         2, 2};
    vecs[3]  = '{0, 1, 32'd8,    32'h0,         3, 0, 1, 32'h5591_0193, 2, 2};
    vecs[4]  = '{1, 0, 32'd6,    32'hDEAD_BEEF, 1, 1, 0, 32'h0,         2, 2};
    vecs[5]  = '{0, 1, 32'd4,    32'h0,         1, 0, 1, 32'hE750_8113, 2, 2};
    vecs[6]  = '{1, 0, 32'd1024, 32'h1234_5678, 1, 1, 0, 32'h0,         2, 2};
    vecs[7]  = '{1, 0, 32'd12,   32'h00A0_0093, 2, 0, 0, 32'h0,         3, 3};
    vecs[8]  = '{0, 1, 32'd1024, 32'h0,         1, 1, 0, 32'h0,         3, 3};
    vecs[9]  = '{1, 0, 32'd16,   32'h1111_1111, 1, 0, 0, 32'h0,         4, 3};
    vecs[10] = '{0, 1, 32'd16,   32'h0,         2, 0, 1, 32'h1111_1111, 4, 3};

    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    check("reset_count", {16'd0, count}, 32'd0);
    check("reset_fetch", fetch_instr, 32'd0);
    @(negedge clk) rst = 0;
    cyc(1);

    foreach (vecs[i]) begin
      model_op(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data, e_m, rv_m, known, exp_f);
      do_op(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data, vecs[i].hold, rv_seen, rv_d);
      check($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vecs[i].err});
      check($sformatf("vec%0d_rv", i), rv_seen, vecs[i].rv);
      if (vecs[i].rv != 0) check($sformatf("vec%0d_data", i), rv_d, vecs[i].rdata);
      check($sformatf("vec%0d_count", i), {16'd0, count}, vecs[i].cnt);
      check($sformatf("vec%0d_sat", i), {30'd0, s_count}, vecs[i].sat);
    end

    // Read latency: pulse two edges after the sampled rising edge, exactly one cycle wide.
    rd_en = 1; addr = 32'd4;
    cyc(1);
    check("lat_busy", {31'd0, busy}, 32'd1);
    check("lat_early", {31'd0, rd_valid}, 32'd0);
    cyc(1);
    check("lat_valid", {31'd0, rd_valid}, 32'd1);
    check("lat_data", rd_data, 32'hE750_8113);
    rd_en = 0;
    cyc(1);
    check("lat_pulse_end", {31'd0, rd_valid}, 32'd0);
    check("lat_data_hold", rd_data, 32'hE750_8113);
    cyc(2);

    // Collision on addr 12 while the core fetches addr 12.
    fetch_addr = 32'd12;
    cyc(2);
    check("coll_pre_fetch", fetch_instr, 32'h00A0_0093);
    rv_seen = rv_cnt;
    model_op(1, 1, 32'd12, 32'hCAFE_0013, e_m, rv_m, known, exp_f);
    wr_en = 1; rd_en = 1; addr = 32'd12; instr = 32'hCAFE_0013;
    cyc(1);
    check("coll_busy", {31'd0, busy}, 32'd1);
    check("coll_fetch_old", fetch_instr, 32'h00A0_0093);
    cyc(1);
    check("coll_stall", {31'd0, fetch_stall}, 32'd1);
    check("coll_fetch_hold", fetch_instr, 32'h00A0_0093);
    check("coll_err", {31'd0, err}, 32'd1);
    wr_en = 0; rd_en = 0;
    cyc(1);
    check("coll_stall_end", {31'd0, fetch_stall}, 32'd0);
    check("coll_fetch_new", fetch_instr, 32'hCAFE_0013);
    cyc(3);
    check("coll_no_rv", rv_cnt - rv_seen, 32'd0);
    check("coll_count", {16'd0, count}, 32'd5);
    check("sat_count", {30'd0, s_count}, 32'd3);
    fetch_addr = 32'd4;
    cyc(1);
    check("fetch_addr4", fetch_instr, 32'hE750_8113);
    fetch_addr = 32'd6;
    cyc(1);
    check("fetch_misaligned", fetch_instr, 32'h0000_0013);
    fetch_addr = 32'd1024;
    cyc(1);
    check("fetch_range", fetch_instr, 32'h0000_0013);

    // Randomized ops against the model.
    for (int n = 0; n < 60; n++) begin
      bit          w, r;
      int          k;
      logic [31:0] a, d, fa;
      k = int'($urandom_range(0, 9));
      w = (k < 4) || (k == 8);
      r = (k >= 4);
      case ($urandom_range(0, 5))
        0:       a = 32'd1024 + ($urandom_range(0, 255) << 2);
        1:       a = ($urandom_range(0, 63) << 2) | $urandom_range(1, 3);
        2:       a = 32'd1020;
        default: a = $urandom_range(0, 15) << 2;
      endcase
      d = $urandom;
      model_op(w, r, a, d, e_m, rv_m, known, exp_f);
      do_op(w, r, a, d, int'($urandom_range(1, 3)), rv_seen, rv_d);
      check($sformatf("rnd%0d_err", n), {31'd0, err}, {31'd0, e_m});
      check($sformatf("rnd%0d_rv", n), rv_seen, rv_m);
      if (rv_m != 0 && known) check($sformatf("rnd%0d_data", n), rv_d, exp_f);
      check($sformatf("rnd%0d_count", n), {16'd0, count}, cnt_m);
      check($sformatf("rnd%0d_sat", n), {30'd0, s_count}, sat_m);
      fa = ($urandom_range(0, 3) == 0) ? 32'($urandom) : ($urandom_range(0, 15) << 2);
      fetch_addr = fa;
      cyc(1);
      if (!legal(fa)) check($sformatf("rnd%0d_fetch_nop", n), fetch_instr, 32'h0000_0013);
      else if (wr_m[fa >> 2]) check($sformatf("rnd%0d_fetch", n), fetch_instr, mem_m[fa >> 2]);
    end

    // Reset mid-WRITE: outputs clear immediately and the write is abandoned.
    wr_en = 1; addr = 32'd8; instr = 32'h0BAD_BAD0;
    cyc(1);
    check("abort_in_write", {31'd0, busy}, 32'd1);
    #2 rst = 1;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_count", {16'd0, count}, 32'd0);
    check("rst_sat", {30'd0, s_count}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_rd", {rd_data[31:1], rd_data[0] | rd_valid}, 32'd0);
    check("rst_fetch", {fetch_instr[31:1], fetch_instr[0] | fetch_stall}, 32'd0);
    wr_en = 0;
    cyc(2);
    @(negedge clk) rst = 0;
    cnt_m = 0; sat_m = 0;
    cyc(1);
    do_op(0, 1, 32'd8, 32'h0, 1, rv_seen, rv_d);
    check("abort_rv", rv_seen, 32'd1);
    check("abort_mem_kept", rv_d, mem_m[2]);
    check("abort_count", {16'd0, count}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
